// File: rtl/trace_capture_ctrl_pkg.sv
// trace_capture_ctrl_pkg: shared definitions for the trace capture sequencer.
//   - capture state encoding (2 bits)
//   - status-bit positions used by the trace register block
// The arm-timeout feature is compiled in only when TRACE_CAPTURE_TIMEOUT_EN
// is defined. It is off by default.
package trace_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // Bit positions of the capture status word read over USB.
  localparam int STAT_DONE_BIT      = 0;
  localparam int STAT_OVERFLOW_BIT  = 1;
  localparam int STAT_SYNC_LOST_BIT = 2;
  localparam int STAT_TIMED_OUT_BIT = 3;
  localparam int STAT_W             = 4;

  function automatic logic [STAT_W-1:0] pack_status(
    input logic done, input logic ovf, input logic sync_lost, input logic timed_out
  );
    logic [STAT_W-1:0] s;
    s = '0;
    s[STAT_DONE_BIT]      = done;
    s[STAT_OVERFLOW_BIT]  = ovf;
    s[STAT_SYNC_LOST_BIT] = sync_lost;
    s[STAT_TIMED_OUT_BIT] = timed_out;
    return s;
  endfunction

endpackage

// File: rtl/trace_capture_ctrl_trig.sv
// trace_capture_ctrl_trig: combinational trigger-rule evaluation.
// Ports:
//   sync_i          decoder frame-synchronized
//   matched_i       per-rule match pulses
//   trig_en_i       rules allowed to trigger
//   soft_en_i       soft trigger allowed
//   soft_i          soft trigger pulse
//   trig_hit_o      a trigger is accepted this cycle (gated by sync)
//   rules_o         enabled rules that matched this cycle
module trace_capture_ctrl_trig #(
  parameter int pMATCH_RULES = 8
) (
  input  logic                    sync_i,
  input  logic [pMATCH_RULES-1:0] matched_i,
  input  logic [pMATCH_RULES-1:0] trig_en_i,
  input  logic                    soft_en_i,
  input  logic                    soft_i,
  output logic                    trig_hit_o,
  output logic [pMATCH_RULES-1:0] rules_o
);

  assign rules_o    = matched_i & trig_en_i;
  assign trig_hit_o = sync_i & ((|rules_o) | (soft_en_i & soft_i));

endmodule

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: arm / trigger / capture / done sequencer feeding the
// trace capture FIFO.
// Ports:
//   trace_clk, reset_i (async, active high)
//   I_arm, I_abort              control pulses (abort > arm > state logic)
//   I_synchronized              decoder sync status
//   I_matched_pattern, I_pattern_trig_enable, I_soft_trig_enable, I_soft_trig
//   I_max_entries               entries to capture (0 = until FIFO full)
//   I_timeout                   arm timeout, used only with TRACE_CAPTURE_TIMEOUT_EN
//   I_data_valid, I_fifo_full   frame stream / FIFO back-pressure
//   O_fifo_wr                   combinational FIFO write strobe
//   O_trigger                   registered one-cycle trigger pulse
//   O_armed/O_capturing/O_done  state decodes
//   O_entry_count, O_trig_rules capture status
//   O_overflow, O_sync_lost, O_timed_out  sticky status flags
// Optional feature macro: TRACE_CAPTURE_TIMEOUT_EN (arm timeout).
module trace_capture_ctrl
  import trace_capture_ctrl_pkg::*;
#(
  parameter int pMATCH_RULES   = 8,
  parameter int pCOUNT_WIDTH   = 16,
  parameter int pTIMEOUT_WIDTH = 24
) (
  input  logic                      trace_clk,
  input  logic                      reset_i,
  input  logic                      I_arm,
  input  logic                      I_abort,
  input  logic                      I_synchronized,
  input  logic [pMATCH_RULES-1:0]   I_matched_pattern,
  input  logic [pMATCH_RULES-1:0]   I_pattern_trig_enable,
  input  logic                      I_soft_trig_enable,
  input  logic                      I_soft_trig,
  input  logic [pCOUNT_WIDTH-1:0]   I_max_entries,
  input  logic [pTIMEOUT_WIDTH-1:0] I_timeout,
  input  logic                      I_data_valid,
  input  logic                      I_fifo_full,
  output logic                      O_fifo_wr,
  output logic                      O_trigger,
  output logic                      O_armed,
  output logic                      O_capturing,
  output logic                      O_done,
  output logic [pCOUNT_WIDTH-1:0]   O_entry_count,
  output logic [pMATCH_RULES-1:0]   O_trig_rules,
  output logic                      O_overflow,
  output logic                      O_sync_lost,
  output logic                      O_timed_out
);

  localparam logic [pCOUNT_WIDTH-1:0] CNT_MAX = '1;

  cap_state_e                state_q, state_d;
  logic [pCOUNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [pMATCH_RULES-1:0]   rules_q, rules_d, hit_rules;
  logic                      trig_q, trig_d;
  logic                      ovf_q, ovf_d;
  logic                      sl_q, sl_d;
  logic                      trig_hit;

  trace_capture_ctrl_trig #(.pMATCH_RULES(pMATCH_RULES)) u_trig (
    .sync_i     (I_synchronized),
    .matched_i  (I_matched_pattern),
    .trig_en_i  (I_pattern_trig_enable),
    .soft_en_i  (I_soft_trig_enable),
    .soft_i     (I_soft_trig),
    .trig_hit_o (trig_hit),
    .rules_o    (hit_rules)
  );

`ifdef TRACE_CAPTURE_TIMEOUT_EN
  localparam logic [pTIMEOUT_WIDTH-1:0] TMO_ONE = 1;
  logic [pTIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic                      to_q, to_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^I_timeout;
`endif

  // Sync loss blocks the write in the same cycle, so it gates the strobe too.
  assign O_fifo_wr = (state_q == ST_CAPTURE) & I_synchronized & I_data_valid & ~I_fifo_full;

  // Counter saturates rather than wrapping.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rules_d = rules_q;
    trig_d  = 1'b0;
    ovf_d   = ovf_q;
    sl_d    = sl_q;
`ifdef TRACE_CAPTURE_TIMEOUT_EN
    tmo_d   = tmo_q;
    to_d    = to_q;
`endif
    if (I_abort) begin
      // Status is kept; a frame written this cycle still counts.
      state_d = ST_IDLE;
      if (O_fifo_wr) cnt_d = cnt_inc;
    end else if (I_arm) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
      rules_d = '0;
      ovf_d   = 1'b0;
      sl_d    = 1'b0;
`ifdef TRACE_CAPTURE_TIMEOUT_EN
      tmo_d   = I_timeout;
      to_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (trig_hit) begin
            // Triggering frame is not written; capture begins next cycle.
            state_d = ST_CAPTURE;
            trig_d  = 1'b1;
            rules_d = hit_rules;
          end
`ifdef TRACE_CAPTURE_TIMEOUT_EN
          // A loaded value of 0 never reaches 1, which disables the timeout.
          else if (tmo_q == TMO_ONE) begin
            state_d = ST_DONE;
            to_d    = 1'b1;
          end else if (tmo_q != '0) begin
            tmo_d = tmo_q - 1'b1;
          end
`endif
        end
        ST_CAPTURE: begin
          if (!I_synchronized) begin
            sl_d    = 1'b1;
            state_d = ST_DONE;
          end else if (I_data_valid && I_fifo_full) begin
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else if (O_fifo_wr) begin
            cnt_d = cnt_inc;
            // Equality against the live limit: a limit lowered below the
            // current count never matches, so capture runs to FIFO full.
            if (I_max_entries != '0 && cnt_inc == I_max_entries) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge trace_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rules_q <= '0;
      trig_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rules_q <= rules_d;
      trig_q  <= trig_d;
      ovf_q   <= ovf_d;
      sl_q    <= sl_d;
    end
  end

`ifdef TRACE_CAPTURE_TIMEOUT_EN
  always_ff @(posedge trace_clk or posedge reset_i) begin
    if (reset_i) begin
      tmo_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      to_q  <= to_d;
    end
  end
  assign O_timed_out = to_q;
`else
  assign O_timed_out = 1'b0;
`endif

  assign O_trigger     = trig_q;
  assign O_armed       = (state_q == ST_ARMED);
  assign O_capturing   = (state_q == ST_CAPTURE);
  assign O_done        = (state_q == ST_DONE);
  assign O_entry_count = cnt_q;
  assign O_trig_rules  = rules_q;
  assign O_overflow    = ovf_q;
  assign O_sync_lost   = sl_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
module tb_trace_capture_ctrl;

  logic        trace_clk = 1'b0;
  logic        reset_i;
  logic        I_arm, I_abort, I_synchronized;
  logic [7:0]  I_matched_pattern, I_pattern_trig_enable;
  logic        I_soft_trig_enable, I_soft_trig;
  logic [15:0] I_max_entries;
  logic [23:0] I_timeout;
  logic        I_data_valid, I_fifo_full;
  logic        O_fifo_wr, O_trigger, O_armed, O_capturing, O_done;
  logic [15:0] O_entry_count;
  logic [7:0]  O_trig_rules;
  logic        O_overflow, O_sync_lost, O_timed_out;

  int tests = 0;
  int fails = 0;
  int wr_cnt, trg_cnt;

  trace_capture_ctrl #(.pMATCH_RULES(8), .pCOUNT_WIDTH(16), .pTIMEOUT_WIDTH(24)) dut (
    .trace_clk(trace_clk), .reset_i(reset_i),
    .I_arm(I_arm), .I_abort(I_abort), .I_synchronized(I_synchronized),
    .I_matched_pattern(I_matched_pattern), .I_pattern_trig_enable(I_pattern_trig_enable),
    .I_soft_trig_enable(I_soft_trig_enable), .I_soft_trig(I_soft_trig),
    .I_max_entries(I_max_entries), .I_timeout(I_timeout),
    .I_data_valid(I_data_valid), .I_fifo_full(I_fifo_full),
    .O_fifo_wr(O_fifo_wr), .O_trigger(O_trigger), .O_armed(O_armed),
    .O_capturing(O_capturing), .O_done(O_done), .O_entry_count(O_entry_count),
    .O_trig_rules(O_trig_rules), .O_overflow(O_overflow), .O_sync_lost(O_sync_lost),
    .O_timed_out(O_timed_out)
  );

  always #5 trace_clk = ~trace_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge trace_clk);
    #1;
  endtask

  // Run n cycles, counting write strobes and trigger pulses seen before each edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (O_fifo_wr) wr_cnt++;
      if (O_trigger) trg_cnt++;
      tick();
    end
  endtask

  task automatic pulse_arm();
    I_arm = 1'b1; tick(); I_arm = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; I_arm = 0; I_abort = 0; I_synchronized = 1;
    I_matched_pattern = 0; I_pattern_trig_enable = 0;
    I_soft_trig_enable = 0; I_soft_trig = 0; I_max_entries = 0; I_timeout = 0;
    I_data_valid = 0; I_fifo_full = 0;
    #22;
    chk("rst_armed", {31'd0, O_armed}, 0);
    chk("rst_done",  {31'd0, O_done}, 0);
    chk("rst_count", {16'd0, O_entry_count}, 0);
    chk("rst_wr",    {31'd0, O_fifo_wr}, 0);
    reset_i = 1'b0;
    tick();

    // 1: rule-2 trigger, 5 entries
    I_max_entries = 16'd5;
    pulse_arm();
    chk("s1_armed", {31'd0, O_armed}, 1);
    I_pattern_trig_enable = 8'h04; I_matched_pattern = 8'h04; I_data_valid = 1;
    tick();
    I_matched_pattern = 8'h00;
    chk("s1_trigger", {31'd0, O_trigger}, 1);
    chk("s1_capturing", {31'd0, O_capturing}, 1);
    wr_cnt = 0; trg_cnt = 0;
    run(20);
    chk("s1_writes", wr_cnt, 5);
    chk("s1_trig_pulses", trg_cnt, 1);
    chk("s1_count", {16'd0, O_entry_count}, 5);
    chk("s1_done", {31'd0, O_done}, 1);
    chk("s1_rules", {24'd0, O_trig_rules}, 32'h04);

    // 2: non-enabled rule / disabled soft trigger do not fire
    pulse_arm();
    chk("s2_count_clr", {16'd0, O_entry_count}, 0);
    chk("s2_rules_clr", {24'd0, O_trig_rules}, 0);
    I_matched_pattern = 8'h08; tick(); I_matched_pattern = 0;
    chk("s2_rule3_armed", {31'd0, O_armed}, 1);
    chk("s2_rule3_notrig", {31'd0, O_trigger}, 0);
    I_soft_trig = 1; tick(); I_soft_trig = 0;
    chk("s2_soft_armed", {31'd0, O_armed}, 1);
    I_abort = 1; tick(); I_abort = 0;
    chk("s2_abort_idle", {30'd0, O_armed, O_done}, 0);

    // 3: unlimited, FIFO fills after 10 writes
    I_max_entries = 0;
    pulse_arm();
    I_soft_trig_enable = 1; I_soft_trig = 1; tick(); I_soft_trig = 0;
    wr_cnt = 0;
    run(10);
    chk("s3_writes", wr_cnt, 10);
    I_fifo_full = 1; #1;
    chk("s3_wr_full", {31'd0, O_fifo_wr}, 0);
    tick();
    chk("s3_count", {16'd0, O_entry_count}, 10);
    chk("s3_overflow", {31'd0, O_overflow}, 1);
    chk("s3_done", {31'd0, O_done}, 1);
    I_fifo_full = 0;

    // 4: sync loss after 3 writes; unsynchronized trigger ignored
    pulse_arm();
    chk("s4_ovf_clr", {31'd0, O_overflow}, 0);
    I_synchronized = 0; I_soft_trig = 1; tick();
    chk("s4_unsync_armed", {31'd0, O_armed}, 1);
    chk("s4_unsync_notrig", {31'd0, O_trigger}, 0);
    I_synchronized = 1; tick(); I_soft_trig = 0;
    chk("s4_capturing", {31'd0, O_capturing}, 1);
    wr_cnt = 0;
    run(3);
    I_synchronized = 0; #1;
    chk("s4_wr_nosync", {31'd0, O_fifo_wr}, 0);
    tick();
    chk("s4_sync_lost", {31'd0, O_sync_lost}, 1);
    chk("s4_done", {31'd0, O_done}, 1);
    I_synchronized = 1;
    run(4);
    chk("s4_writes", wr_cnt, 3);
    chk("s4_count", {16'd0, O_entry_count}, 3);

    // 5: abort+arm together in CAPTURE, then async reset mid-capture
    pulse_arm();
    I_soft_trig = 1; tick(); I_soft_trig = 0;
    tick(); tick();
    I_abort = 1; I_arm = 1; tick(); I_abort = 0; I_arm = 0;
    chk("s5_abort_state", {29'd0, O_armed, O_capturing, O_done}, 0);
    pulse_arm();
    I_soft_trig = 1; tick(); I_soft_trig = 0;
    tick(); tick();
    #3 reset_i = 1; #1;
    chk("s5_rst_state", {29'd0, O_armed, O_capturing, O_done}, 0);
    chk("s5_rst_count", {16'd0, O_entry_count}, 0);
    chk("s5_rst_wr", {31'd0, O_fifo_wr}, 0);
    chk("s5_rst_rules", {24'd0, O_trig_rules}, 0);
    #3 reset_i = 0;
    tick();

    // 6: arm timeout
    I_data_valid = 0; I_timeout = 24'd100;
    pulse_arm();
`ifdef TRACE_CAPTURE_TIMEOUT_EN
    run(99);
    chk("s6_still_armed", {31'd0, O_armed}, 1);
    tick();
    chk("s6_timed_out", {31'd0, O_timed_out}, 1);
    chk("s6_done", {31'd0, O_done}, 1);
`else
    run(1000);
    chk("s6_armed", {31'd0, O_armed}, 1);
    chk("s6_no_timeout", {31'd0, O_timed_out}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
Sequencer for one trace capture: arm, trigger, capture, done. It sits between the trace trigger logic (pattern-match pulses, sync status) and the capture FIFO, and decides which trace frames are written. Its configuration and status connect to the trace register block and are read over USB.

Parameters:
pMATCH_RULES, 8, number of pattern-match rules
pCOUNT_WIDTH, 16, width of the entry counter and the max-entries limit
pTIMEOUT_WIDTH, 24, width of the arm-timeout counter (used only with the optional feature)

Ports:
trace_clk  input  1  sole clock
reset_i  input  1  asynchronous active-high reset
I_arm  input  1  one-cycle pulse; arms the capture
I_abort  input  1  one-cycle pulse; returns to IDLE from any state
I_synchronized  input  1  trace decoder is frame-synchronized
I_matched_pattern  input  pMATCH_RULES  one-cycle match pulse per rule
I_pattern_trig_enable  input  pMATCH_RULES  rules allowed to trigger
I_soft_trig_enable  input  1  soft trigger allowed
I_soft_trig  input  1  one-cycle soft trigger pulse
I_max_entries  input  pCOUNT_WIDTH  entries to capture; 0 = until FIFO full
I_timeout  input  pTIMEOUT_WIDTH  arm timeout in cycles; 0 = none (optional feature only)
I_data_valid  input  1  trace frame presented this cycle
I_fifo_full  input  1  capture FIFO full
O_fifo_wr  output  1  write the current frame to the FIFO
O_trigger  output  1  one-cycle pulse on trigger acceptance
O_armed  output  1  state == ARMED
O_capturing  output  1  state == CAPTURE
O_done  output  1  state == DONE
O_entry_count  output  pCOUNT_WIDTH  entries written in this capture
O_trig_rules  output  pMATCH_RULES  rules that caused the trigger, latched
O_overflow  output  1  sticky: a frame was dropped because the FIFO was full
O_sync_lost  output  1  sticky: sync was lost during CAPTURE
O_timed_out  output  1  sticky: the arm timeout expired

Behaviour:
- Reset (async, reset_i=1): state=IDLE; all registered outputs and counters 0. O_fifo_wr is combinational and is therefore 0 in IDLE.
- States are IDLE, ARMED, CAPTURE, DONE, with 2-bit encoding from defines_trace.v.
- trig_hit = I_synchronized & ( |(I_matched_pattern & I_pattern_trig_enable) | (I_soft_trig_enable & I_soft_trig) ).
- IDLE -> ARMED on I_arm. Entering ARMED clears O_entry_count, O_trig_rules and all sticky flags in the same edge.
- ARMED -> CAPTURE on trig_hit.
  - O_trigger=1 for exactly one cycle, registered, asserted the cycle after the hit.
  - O_trig_rules <= I_matched_pattern & I_pattern_trig_enable.
  - The triggering frame itself is not written. Capture starts on the next cycle.
- CAPTURE:
  - O_fifo_wr = I_data_valid & ~I_fifo_full (combinational, 0 latency).
  - Each write increments O_entry_count.
  - -> DONE on the write that makes count == I_max_entries (I_max_entries != 0).
  - I_data_valid & I_fifo_full: frame dropped, O_overflow<=1, -> DONE.
  - ~I_synchronized: O_sync_lost<=1, -> DONE. No write that cycle.
  - O_entry_count saturates at all-ones and does not wrap. In unlimited mode the FIFO-full exit ends the capture.
- DONE holds with status stable. I_arm -> ARMED (re-arm, clears status). I_abort -> IDLE.
- Priority in any state: I_abort > I_arm > the state's own transition. I_abort does not clear status. I_arm while ARMED or CAPTURE restarts ARMED and clears status.
- If I_max_entries changes during CAPTURE, the live value is compared. If count already exceeds the new value, capture continues to FIFO full or saturation.

Optional Feature:
TRACE_CAPTURE_TIMEOUT_EN
- Defined:
  - In ARMED, a down-counter is loaded with I_timeout on entry.
  - It decrements each cycle without trig_hit.
  - When it reaches 1 with no hit: O_timed_out<=1, -> DONE.
  - I_timeout==0 disables the timeout.
  - A hit in the same cycle as expiry wins.
- Undefined: I_timeout is ignored, ARMED waits indefinitely, O_timed_out is tied 0.

Decomposition:
- defines_trace.v gains the capture state encodings, status-bit positions for the register block (done, overflow, sync_lost, timed_out), and the TRACE_CAPTURE_TIMEOUT_EN default (off).
- One natural sub-module: trace_capture_trig. It computes trig_hit and the masked rule vector combinationally, so the trigger rule can be reused by other blocks.

Test Plan:
- Arm, trigger from rule 2 (I_pattern_trig_enable=8'h04, match=8'h04), I_max_entries=5, continuous I_data_valid -> O_trigger single pulse, exactly 5 O_fifo_wr, O_entry_count=5, O_done=1, O_trig_rules=8'h04.
- Match on rule 3 with I_pattern_trig_enable=8'h04 -> stays ARMED, no O_trigger. Soft trig with I_soft_trig_enable=0 -> stays ARMED.
- I_max_entries=0, I_fifo_full rises after 10 writes while I_data_valid=1 -> count=10, O_overflow=1, O_done=1.
- Drop I_synchronized after 3 writes -> O_sync_lost=1, count=3, no further writes. A trigger pulse while unsynchronized in ARMED is ignored.
- I_abort and I_arm in the same cycle during CAPTURE -> IDLE. reset_i pulse mid-CAPTURE -> immediate IDLE, all outputs 0 with no clock edge needed.
- With TRACE_CAPTURE_TIMEOUT_EN, I_timeout=100, no trigger -> O_timed_out=1 after 100 cycles in ARMED. Without the macro, the same stimulus leaves the block ARMED after 1000 cycles.
